// File: rtl/temp_sample_feeder.sv
// Temperature sample feeder: boxcar-averages raw Q7.4 beats and produces a rounded, saturated Q7.0 T_cur with init/t_strobe pulses.
// Optional TSF_SLEW_LIMIT_EN limits each RUN-mode T_cur step to SLEW_MAX.
module temp_sample_feeder #(
  parameter int RAW_W       = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SLEW_MAX    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sensor_fault,
  input  logic                    raw_valid,
  output logic                    raw_ready,
  input  logic signed [RAW_W-1:0] raw_data,
  output logic signed [7:0]       T_cur,
  output logic                    t_strobe,
  output logic                    init
);

  localparam int ACC_W = RAW_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic signed [ACC_W:0] RND  = 8;
  localparam logic signed [ACC_W:0] TMAX = 127;
  localparam logic signed [ACC_W:0] TMIN = -128;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  // Average then round half toward +inf; one guard bit keeps avg+8 from wrapping.
  function automatic logic signed [ACC_W:0] round_q74(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] avg;
    avg = (ACC_W+1)'(sum) >>> AVG_LOG2;
    return (avg + RND) >>> 4;
  endfunction

  function automatic logic signed [7:0] sat_q70(input logic signed [ACC_W:0] t);
    if (t > TMAX) return 8'sd127;
    if (t < TMIN) return -8'sd128;
    return t[7:0];
  endfunction

  function automatic logic signed [7:0] slew_step(input logic signed [7:0] cur,
                                                  input logic signed [7:0] tgt);
    logic signed [8:0] diff;
    logic signed [8:0] lim;
    diff = 9'(tgt) - 9'(cur);
    lim  = 9'(SLEW_MAX);
    if (diff > lim)  return 8'(9'(cur) + lim);
    if (diff < -lim) return 8'(9'(cur) - lim);
    return tgt;
  endfunction

  logic [1:0]              r_state;
  logic                    r_raw_ready;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic signed [7:0]       r_tcur_p1;
  logic                    r_init_p1;
  logic                    r_strobe_p1;

  logic [1:0]              w_state_nxt;
  logic                    w_active;
  logic                    w_active_nxt;
  logic                    w_accept;
  logic                    w_complete;
  logic signed [ACC_W-1:0] w_sum_p0;
  logic signed [7:0]       w_t_new_p0;

  assign w_accept   = raw_valid & r_raw_ready;
  assign w_active   = (r_state == S_PRIME) || (r_state == S_RUN);
  assign w_sum_p0   = r_acc + ACC_W'(raw_data);
  assign w_t_new_p0 = sat_q70(round_q74(w_sum_p0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_PRIME;
      S_PRIME, S_RUN: begin
        if (sensor_fault || (r_to_cnt == TO_LAST))
          w_state_nxt = S_FAULT;
        else if (w_accept && (r_beat_cnt == LAST_BEAT) && (r_state == S_PRIME))
          w_state_nxt = S_RUN;
      end
      S_FAULT: if (!sensor_fault && raw_valid) w_state_nxt = S_PRIME;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!enable) w_state_nxt = S_IDLE;
  end

  assign w_active_nxt = (w_state_nxt == S_PRIME) || (w_state_nxt == S_RUN);
  // A group only completes if the block stays in PRIME/RUN; aborts drop it.
  assign w_complete   = w_accept && (r_beat_cnt == LAST_BEAT) && w_active_nxt;

  // Stage p0 -> p1: accumulate beats, register T_cur and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_raw_ready <= 1'b0;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_to_cnt    <= '0;
      r_tcur_p1   <= '0;
      r_init_p1   <= 1'b0;
      r_strobe_p1 <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_raw_ready <= w_active_nxt;
      r_init_p1   <= w_complete && (r_state == S_PRIME);
      r_strobe_p1 <= w_complete && (r_state == S_RUN);

      if (!w_active_nxt || w_complete) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_acc      <= w_sum_p0;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end

      if (!w_active || !w_active_nxt || w_accept)
        r_to_cnt <= '0;
      else if (r_to_cnt != TO_LAST)
        r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_complete) begin
`ifdef TSF_SLEW_LIMIT_EN
        r_tcur_p1 <= (r_state == S_PRIME) ? w_t_new_p0 : slew_step(r_tcur_p1, w_t_new_p0);
`else
        r_tcur_p1 <= w_t_new_p0;
`endif
      end
    end
  end

  assign raw_ready = r_raw_ready;
  assign T_cur     = r_tcur_p1;
  assign init      = r_init_p1;
  assign t_strobe  = r_strobe_p1;

endmodule
